// File: rtl/imem_arbiter.sv
// ============================================================================
// imem_arbiter: BOOT/RUN controller and round-robin arbiter for the imem port
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_arbiter #(
   parameter int AW    = 5,
   parameter int DW    = 32,
   parameter int DEPTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             boot_done,
   input  logic             reload,
   input  logic             f_req,
   input  logic [AW-1:0]    f_addr,
   output logic             f_gnt,
   output logic             f_valid,
   output logic [DW-1:0]    f_rdata,
   output logic             f_err,
   input  logic             l_req,
   input  logic             l_we,
   input  logic [AW-1:0]    l_addr,
   input  logic [DW-1:0]    l_wdata,
   output logic             l_gnt,
   output logic             l_valid,
   output logic [DW-1:0]    l_rdata,
   output logic [AW-1:0]    mem_a,
   output logic             mem_we,
   output logic [DW-1:0]    mem_wd,
   input  logic [DW-1:0]    mem_rd,
   output logic             core_run,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      BOOT = 2'b00,
      RUN  = 2'b01
   } state_t;

   localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

   state_t r_state;
   state_t w_next_state;
   logic   r_rr;
   logic   w_f_in_range;
   logic   w_l_in_range;

   assign w_f_in_range = ({1'b0, f_addr} < c_DEPTH);
   assign w_l_in_range = ({1'b0, l_addr} < c_DEPTH);

   // r_rr=0 favours fetch on a tie, r_rr=1 favours the loader
   always_comb begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
      if (r_state == RUN) begin
         if (f_req && l_req) begin
            f_gnt = !r_rr;
            l_gnt = r_rr;
         end else begin
            f_gnt = f_req;
            l_gnt = l_req;
         end
      end else begin
         l_gnt = l_req;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (r_state == BOOT && boot_done)
         w_next_state = RUN;
      else if (r_state == RUN && reload)
         w_next_state = BOOT;
   end

   assign mem_a  = f_gnt ? f_addr : (l_gnt ? l_addr : '0);
   assign mem_we = l_gnt & l_we & w_l_in_range;
   assign mem_wd = l_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= BOOT;
         r_rr      <= 1'b0;
         f_valid   <= 1'b0;
         l_valid   <= 1'b0;
         f_rdata   <= '0;
         l_rdata   <= '0;
         f_err     <= 1'b0;
         core_run  <= 1'b0;
         stall_cnt <= '0;
      end else begin
         r_state  <= w_next_state;
         core_run <= (w_next_state == RUN);
         f_valid  <= f_gnt;
         l_valid  <= l_gnt;

         if (f_gnt)
            r_rr <= 1'b1;
         else if (l_gnt)
            r_rr <= 1'b0;

         // Out-of-range fetches return a NOP and flag the error
         if (f_gnt) begin
            f_rdata <= w_f_in_range ? mem_rd : '0;
            f_err   <= !w_f_in_range;
         end

         if (l_gnt)
            l_rdata <= l_we ? l_wdata : mem_rd;

         if (f_req && !f_gnt && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
// ============================================================================
// tb_imem_arbiter: randomized self-checking bench with a behavioural model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imem_arbiter;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 21;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             boot_done = 1'b0, reload = 1'b0;
   logic             f_req = 1'b0, l_req = 1'b0, l_we = 1'b0;
   logic [AW-1:0]    f_addr = '0, l_addr = '0;
   logic [DW-1:0]    l_wdata = '0;
   logic             f_gnt, f_valid, f_err, l_gnt, l_valid, mem_we, core_run;
   logic [DW-1:0]    f_rdata, l_rdata, mem_wd, mem_rd;
   logic [AW-1:0]    mem_a;
   logic [CNT_W-1:0] stall_cnt;

   imem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .boot_done(boot_done), .reload(reload),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid),
      .f_rdata(f_rdata), .f_err(f_err),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_valid(l_valid), .l_rdata(l_rdata),
      .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .core_run(core_run), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Memory array attached to the DUT: combinational read, synchronous write
   logic          init_done = 1'b0;
   logic [DW-1:0] env_mem [32];
   assign mem_rd = env_mem[mem_a];
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 32; i++) env_mem[i] <= '0;
      end else if (mem_we) begin
         env_mem[mem_a] <= mem_wd;
      end
   end

   // Reference model state
   bit            m_run, m_fetch_turn, m_fv, m_lv, m_fe;
   logic [DW-1:0] m_fd, m_ld;
   int            m_stall;
   logic [DW-1:0] m_mem [32];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset;
      m_run = 0; m_fetch_turn = 1; m_fv = 0; m_lv = 0; m_fe = 0;
      m_fd = '0; m_ld = '0; m_stall = 0;
   endtask

   // One clock cycle: drive, check grants, clock, update model, check responses
   task automatic step(input logic bf, rl, fr, input logic [AW-1:0] fa,
                       input logic lr, lw, input logic [AW-1:0] la, input logic [DW-1:0] lwd);
      bit            exp_fg, exp_lg, exp_we;
      logic [AW-1:0] exp_a;
      boot_done = bf; reload = rl; f_req = fr; f_addr = fa;
      l_req = lr; l_we = lw; l_addr = la; l_wdata = lwd;
      #1;
      if (!m_run) begin
         exp_fg = 0; exp_lg = lr;
      end else if (fr && lr) begin
         exp_fg = m_fetch_turn; exp_lg = !m_fetch_turn;
      end else begin
         exp_fg = fr; exp_lg = lr;
      end
      exp_we = exp_lg && lw && (int'(la) < DEPTH);
      exp_a  = exp_fg ? fa : (exp_lg ? la : '0);
      check_eq("f_gnt", f_gnt, exp_fg);
      check_eq("l_gnt", l_gnt, exp_lg);
      check_eq("mem_we", mem_we, exp_we);
      check_eq("mem_a", mem_a, exp_a);
      if (exp_we) check_eq("mem_wd", mem_wd, lwd);

      @(posedge clk);
      m_fv = exp_fg;
      m_lv = exp_lg;
      if (exp_fg) begin
         m_fe = (int'(fa) >= DEPTH);
         m_fd = m_fe ? '0 : m_mem[fa];
         m_fetch_turn = 0;
      end
      if (exp_lg) begin
         m_ld = lw ? lwd : m_mem[la];
         if (exp_we) m_mem[la] = lwd;
         m_fetch_turn = 1;
      end
      if (fr && !exp_fg && m_stall < 65535) m_stall++;
      if (!m_run && bf) m_run = 1;
      else if (m_run && rl) m_run = 0;

      #1;
      check_eq("f_valid", f_valid, m_fv);
      check_eq("l_valid", l_valid, m_lv);
      check_eq("core_run", core_run, m_run);
      check_eq("stall_cnt", stall_cnt, m_stall);
      check_eq("f_rdata", f_rdata, m_fd);
      check_eq("l_rdata", l_rdata, m_ld);
      if (m_fv) check_eq("f_err", f_err, m_fe);
      @(negedge clk);
   endtask

   task automatic do_reset;
      #1 rst_n = 1'b0;
      #1;
      check_eq("rst_f_valid", f_valid, 0);
      check_eq("rst_l_valid", l_valid, 0);
      check_eq("rst_core_run", core_run, 0);
      check_eq("rst_stall", stall_cnt, 0);
      check_eq("rst_f_rdata", f_rdata, 0);
      check_eq("rst_l_rdata", l_rdata, 0);
      check_eq("rst_f_err", f_err, 0);
      model_reset();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      model_reset();
      repeat (2) @(posedge clk);
      init_done = 1'b1;
      @(negedge clk);
      do_reset();

      // BOOT: fetch waits and stalls
      repeat (3) step(0, 0, 1, 5'd0, 0, 0, 5'd0, 32'h0);
      // Loader write then read-back of address 0
      step(0, 0, 0, 5'd0, 1, 1, 5'd0, 32'h2010000F);
      step(0, 0, 0, 5'd0, 1, 0, 5'd0, 32'h0);
      step(0, 0, 0, 5'd0, 1, 1, 5'd1, 32'hCAFE0001);
      // reload in BOOT is ignored, then boot
      step(0, 1, 0, 5'd0, 0, 0, 5'd0, 32'h0);
      step(1, 0, 0, 5'd0, 0, 0, 5'd0, 32'h0);
      step(0, 0, 1, 5'd0, 0, 0, 5'd0, 32'h0);
      step(0, 0, 0, 5'd0, 0, 0, 5'd0, 32'h0);
      // Contention: both held four cycles
      repeat (4) step(0, 0, 1, 5'd0, 1, 0, 5'd1, 32'h0);
      // Out-of-range fetch and loader accesses
      step(0, 0, 1, 5'd25, 0, 0, 5'd0, 32'h0);
      step(0, 0, 0, 5'd0, 1, 1, 5'd25, 32'hDEADBEEF);
      step(0, 0, 0, 5'd0, 1, 0, 5'd25, 32'h0);
      step(0, 0, 1, 5'd20, 0, 0, 5'd0, 32'h0);
      // Write followed immediately by a fetch of the same address
      step(0, 0, 0, 5'd0, 1, 1, 5'd3, 32'h12345678);
      step(0, 0, 1, 5'd3, 0, 0, 5'd0, 32'h0);
      // boot_done in RUN is ignored; reload wins over boot_done in RUN
      step(1, 0, 0, 5'd0, 0, 0, 5'd0, 32'h0);
      step(1, 1, 1, 5'd3, 0, 0, 5'd0, 32'h0);
      step(0, 0, 1, 5'd3, 0, 0, 5'd0, 32'h0);
      // Boot again and reset while a fetch response is valid
      step(1, 1, 0, 5'd0, 0, 0, 5'd0, 32'h0);
      step(0, 0, 1, 5'd0, 0, 0, 5'd0, 32'h0);
      do_reset();
      step(0, 0, 1, 5'd0, 1, 0, 5'd0, 32'h0);

      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         step($urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0,
              1'($urandom), 5'($urandom_range(0, 31)),
              1'($urandom), 1'($urandom), 5'($urandom_range(0, 31)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
